wb_stage: RTL and testbench

- Writeback stage directly downstream of the EX/MEM pipeline latch.
- Consumes the latched ALU result, the write-enable flag, the destination register and the load-pending flag, plus data-memory port-B read data.
- Formats load data (byte/half/word, signed/unsigned) and produces the registered register-file write port.
- Stalls upstream while a load waits out the memory read latency.

---
 rtl/wb_stage.sv | 158 +++++++++++++++
 tb/tb_wb_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: formats load data and drives the registered register-file write port.
// Optional feature macro: WB_MISALIGN_CHECK_EN (adds misalignErr and suppresses misaligned writes).
module wb_stage #(
  parameter int LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu,
  input  logic        aluToReg,
  input  logic [4:0]  rd,
  input  logic        doutBValid,
  input  logic [2:0]  loadFunct3,
  input  logic [31:0] doutB,
  output logic        rfWe,
  output logic [4:0]  rfAddr,
  output logic [31:0] rfData,
  output logic        stallOut
`ifdef WB_MISALIGN_CHECK_EN
  ,
  output logic        misalignErr
`endif
);

  // state | meaning
  // IDLE  | pass ALU results through, accept a load
  // WAIT  | load accepted, counting down the memory read latency
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] LAT_START = 3'(LOAD_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_addr_q, rf_addr_d;
  logic [31:0] rf_data_q, rf_data_d;
  logic [31:0] load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        misalign;
`ifdef WB_MISALIGN_CHECK_EN
  logic        mis_q, mis_d;
`endif

  always_comb begin
    byte_sel = doutB[7:0];
    case (off_q)
      2'd0: byte_sel = doutB[7:0];
      2'd1: byte_sel = doutB[15:8];
      2'd2: byte_sel = doutB[23:16];
      2'd3: byte_sel = doutB[31:24];
      default: byte_sel = doutB[7:0];
    endcase
    half_sel = off_q[1] ? doutB[31:16] : doutB[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = doutB;
    endcase
  end

`ifdef WB_MISALIGN_CHECK_EN
  assign misalign = (((f3_q == 3'b001) || (f3_q == 3'b101)) && off_q[0]) ||
                    ((f3_q == 3'b010) && (off_q != 2'd0));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_d      = rd_q;
    f3_d      = f3_q;
    off_d     = off_q;
    we_d      = we_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
`ifdef WB_MISALIGN_CHECK_EN
    mis_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (doutBValid) begin
          rd_d    = rd;
          f3_d    = loadFunct3;
          off_d   = alu[1:0];
          we_d    = aluToReg;
          count_d = LAT_START;
          state_d = WAIT;
        end else begin
          rf_we_d   = aluToReg && (rd != 5'd0);
          rf_addr_d = rd;
          rf_data_d = alu;
        end
      end
      WAIT: begin
        if (count_q != 3'd0) begin
          count_d = count_q - 3'd1;
        end else begin
          // doutB is valid on this cycle only; commit the formatted load
          rf_we_d   = we_q && (rd_q != 5'd0) && !misalign;
          rf_addr_d = rd_q;
          rf_data_d = load_data;
`ifdef WB_MISALIGN_CHECK_EN
          mis_d     = misalign;
`endif
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= 3'd0;
      rd_q      <= 5'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      we_q      <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= 5'd0;
      rf_data_q <= 32'd0;
`ifdef WB_MISALIGN_CHECK_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_q      <= rd_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      we_q      <= we_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
`ifdef WB_MISALIGN_CHECK_EN
      mis_q     <= mis_d;
`endif
    end
  end

  assign rfWe     = rf_we_q;
  assign rfAddr   = rf_addr_q;
  assign rfData   = rf_data_q;
  assign stallOut = (state_q == WAIT);
`ifdef WB_MISALIGN_CHECK_EN
  assign misalignErr = mis_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: table of directed vectors at LOAD_LAT=1, hand sequences at LOAD_LAT=3.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu;
  logic        aluToReg;
  logic [4:0]  rd;
  logic        doutBValid;
  logic [2:0]  loadFunct3;
  logic [31:0] doutB;

  logic        we1, we3, st1, st3;
  logic [4:0]  ad1, ad3;
  logic [31:0] dt1, dt3;
`ifdef WB_MISALIGN_CHECK_EN
  logic        mis1, mis3;
`endif

  int checks = 0;
  int errors = 0;
  bit sel3 = 1'b0;

  logic        o_we, o_st;
  logic [4:0]  o_ad;
  logic [31:0] o_dt;
  assign o_we = sel3 ? we3 : we1;
  assign o_st = sel3 ? st3 : st1;
  assign o_ad = sel3 ? ad3 : ad1;
  assign o_dt = sel3 ? dt3 : dt1;

  wb_stage #(.LOAD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .alu(alu), .aluToReg(aluToReg), .rd(rd),
    .doutBValid(doutBValid), .loadFunct3(loadFunct3), .doutB(doutB),
    .rfWe(we1), .rfAddr(ad1), .rfData(dt1), .stallOut(st1)
`ifdef WB_MISALIGN_CHECK_EN
    , .misalignErr(mis1)
`endif
  );

  wb_stage #(.LOAD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .alu(alu), .aluToReg(aluToReg), .rd(rd),
    .doutBValid(doutBValid), .loadFunct3(loadFunct3), .doutB(doutB),
    .rfWe(we3), .rfAddr(ad3), .rfData(dt3), .stallOut(st3)
`ifdef WB_MISALIGN_CHECK_EN
    , .misalignErr(mis3)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic        we;
    logic [4:0]  rd;
    logic        dv;
    logic [2:0]  f3;
    logic [31:0] doutb;
    logic        ewe;
    logic [4:0]  eaddr;
    logic [31:0] edata;
    logic        emis;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one instruction, wait for it to retire, and compare the write port.
  task automatic run_vec(input string name, input vec_t v, input int lat);
    int  stalls;
    bit  we_in_stall;
    alu = v.alu; aluToReg = v.we; rd = v.rd; doutBValid = v.dv;
    loadFunct3 = v.f3; doutB = v.doutb;
    stalls = 0;
    we_in_stall = 1'b0;
    if (v.dv) begin
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (!o_st) break;
        stalls++;
        if (o_we) we_in_stall = 1'b1;
      end
      check({name, " stall_cycles"}, 32'(stalls), 32'(lat));
      check({name, " we_during_stall"}, {31'd0, we_in_stall}, 32'd0);
    end else begin
      @(posedge clk); #1;
      check({name, " stall"}, {31'd0, o_st}, 32'd0);
    end
    check({name, " rfWe"}, {31'd0, o_we}, {31'd0, v.ewe});
    check({name, " rfAddr"}, {27'd0, o_ad}, {27'd0, v.eaddr});
    check({name, " rfData"}, o_dt, v.edata);
`ifdef WB_MISALIGN_CHECK_EN
    check({name, " misalignErr"}, {31'd0, sel3 ? mis3 : mis1}, {31'd0, v.emis});
`endif
    doutBValid = 1'b0;
  endtask

  logic mis_exp;
  logic mis_we;
  vec_t v;
  bit   bad_we, bad_st;

  initial begin
`ifdef WB_MISALIGN_CHECK_EN
    mis_exp = 1'b1; mis_we = 1'b0;
`else
    mis_exp = 1'b0; mis_we = 1'b1;
`endif
    //           alu           we  rd     dv  f3     doutB          ewe  eaddr  edata          emis
    vecs[0]  = '{32'hDEADBEEF, 1, 5'd5,  0, 3'b000, 32'h0,         1,   5'd5,  32'hDEADBEEF, 0};
    vecs[1]  = '{32'h00001234, 1, 5'd0,  0, 3'b000, 32'h0,         0,   5'd0,  32'h00001234, 0};
    vecs[2]  = '{32'h0000ABCD, 0, 5'd3,  0, 3'b000, 32'h0,         0,   5'd3,  32'h0000ABCD, 0};
    vecs[3]  = '{32'h00000103, 1, 5'd7,  1, 3'b000, 32'h80112233,  1,   5'd7,  32'hFFFFFF80, 0};
    vecs[4]  = '{32'h00000103, 1, 5'd7,  1, 3'b100, 32'h80112233,  1,   5'd7,  32'h00000080, 0};
    vecs[5]  = '{32'h00000100, 1, 5'd8,  1, 3'b000, 32'h80112233,  1,   5'd8,  32'h00000033, 0};
    vecs[6]  = '{32'h00000101, 1, 5'd8,  1, 3'b000, 32'h80112233,  1,   5'd8,  32'h00000022, 0};
    vecs[7]  = '{32'h00000102, 1, 5'd9,  1, 3'b000, 32'h00F50000,  1,   5'd9,  32'hFFFFFFF5, 0};
    vecs[8]  = '{32'h00000102, 1, 5'd9,  1, 3'b100, 32'h00F50000,  1,   5'd9,  32'h000000F5, 0};
    vecs[9]  = '{32'h00000102, 1, 5'd10, 1, 3'b001, 32'h8001ABCD,  1,   5'd10, 32'hFFFF8001, 0};
    vecs[10] = '{32'h00000102, 1, 5'd10, 1, 3'b101, 32'h8001ABCD,  1,   5'd10, 32'h00008001, 0};
    vecs[11] = '{32'h00000100, 1, 5'd10, 1, 3'b001, 32'h8001ABCD,  1,   5'd10, 32'hFFFFABCD, 0};
    vecs[12] = '{32'h00000100, 1, 5'd10, 1, 3'b101, 32'h8001ABCD,  1,   5'd10, 32'h0000ABCD, 0};
    vecs[13] = '{32'h00000100, 1, 5'd11, 1, 3'b010, 32'h12345678,  1,   5'd11, 32'h12345678, 0};
    vecs[14] = '{32'h00000100, 1, 5'd12, 1, 3'b011, 32'h89ABCDEF,  1,   5'd12, 32'h89ABCDEF, 0};
    vecs[15] = '{32'h00000100, 1, 5'd12, 1, 3'b111, 32'h00000080,  1,   5'd12, 32'h00000080, 0};
    vecs[16] = '{32'h00000102, 1, 5'd13, 1, 3'b010, 32'hCAFEBABE,  mis_we, 5'd13, 32'hCAFEBABE, mis_exp};
    vecs[17] = '{32'h00000100, 0, 5'd14, 1, 3'b010, 32'h0BADF00D,  0,   5'd14, 32'h0BADF00D, 0};
    vecs[18] = '{32'h00000103, 1, 5'd15, 1, 3'b001, 32'h8001ABCD,  mis_we, 5'd15, 32'hFFFF8001, mis_exp};
    vecs[19] = '{32'h00000042, 1, 5'd1,  0, 3'b000, 32'h0,         1,   5'd1,  32'h00000042, 0};

    reset = 1'b0; alu = '0; aluToReg = 1'b0; rd = '0; doutBValid = 1'b0;
    loadFunct3 = '0; doutB = '0;
    #12;
    check("reset rfWe", {31'd0, we1}, 32'd0);
    check("reset rfAddr", {27'd0, ad1}, 32'd0);
    check("reset rfData", dt1, 32'd0);
    check("reset stallOut", {31'd0, st1}, 32'd0);
    #1 reset = 1'b1;

    sel3 = 1'b0;
    for (int i = 0; i < 20; i++) run_vec($sformatf("lat1_vec%0d", i), vecs[i], 1);

    // LOAD_LAT=3: rd=0 load followed directly by a second load
    sel3 = 1'b1;
    reset = 1'b0; #2 reset = 1'b1;
    v = '{32'h00000200, 1, 5'd0, 1, 3'b010, 32'h11112222, 0, 5'd0, 32'h11112222, 0};
    run_vec("lat3_rd0_load", v, 3);
    v = '{32'h00000202, 1, 5'd9, 1, 3'b001, 32'h7FFF0000, 1, 5'd9, 32'h00007FFF, 0};
    run_vec("lat3_b2b_load", v, 3);
    v = '{32'h00000201, 1, 5'd20, 1, 3'b000, 32'h0000A500, 1, 5'd20, 32'hFFFFFFA5, 0};
    run_vec("lat3_b2b_lb", v, 3);

    // Asynchronous reset in the middle of a load wait
    v = '{32'h000055AA, 1, 5'd4, 0, 3'b000, 32'h0, 1, 5'd4, 32'h000055AA, 0};
    run_vec("lat3_alu_pre", v, 3);
    alu = 32'h300; aluToReg = 1'b1; rd = 5'd6; doutBValid = 1'b1;
    loadFunct3 = 3'b010; doutB = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midwait stallOut", {31'd0, o_st}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort stallOut", {31'd0, o_st}, 32'd0);
    check("abort rfWe", {31'd0, o_we}, 32'd0);
    check("abort rfAddr", {27'd0, o_ad}, 32'd0);
    check("abort rfData", o_dt, 32'd0);
    doutBValid = 1'b0; aluToReg = 1'b0;
    #2 reset = 1'b1;
    bad_we = 1'b0; bad_st = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (o_we) bad_we = 1'b1;
      if (o_st) bad_st = 1'b1;
    end
    check("post_abort no write", {31'd0, bad_we}, 32'd0);
    check("post_abort no stall", {31'd0, bad_st}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
